// File: rtl/expr_result_misr.sv
// expr_result_misr
// Compacts the 90-bit expression result bus into a 32-bit MISR signature.
// A run is armed by start with a vector count; each accepted vector is folded
// to 32 bits and shifted into the MISR. After the last vector the block sits
// in DONE and reports whether the signature equals the golden value.
//
// Ports:
//   clk, rst_n       clock (rising edge), async active-low reset
//   start, abort     run control (abort has priority)
//   num_vec          vectors per run, latched on start
//   in_valid/in_ready/in_y   vector input handshake
//   golden           expected signature (combinational into match)
//   sig, count       current signature and vectors accepted this run
//   done, match      DONE level, and DONE with sig == golden
//   overrun          sticky: in_valid seen while not accepting
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; sig/count hold last values
// RUN   | accepting vectors until num_vec have been folded in
// DONE  | run complete; sig/count hold, start re-arms
module expr_result_misr #(
    parameter logic [31:0] SEED = 32'h0000_0000,
    parameter logic [31:0] POLY = 32'h0040_0007,
    parameter int          CW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_vec,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [89:0]   in_y,
    input  logic [31:0]   golden,
    output logic [31:0]   sig,
    output logic [CW-1:0] count,
    output logic          done,
    output logic          match,
    output logic          overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   sig_q, sig_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] num_vec_q, num_vec_d;
    logic          overrun_q, overrun_d;

    logic [31:0]   fold_w;
    logic [31:0]   misr_w;
    logic [CW-1:0] count_inc;

    assign fold_w    = in_y[31:0] ^ in_y[63:32] ^ {6'b0, in_y[89:64]};
    assign misr_w    = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ fold_w;
    assign count_inc = count_q + {{(CW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        count_d   = count_q;
        num_vec_d = num_vec_q;
        overrun_d = overrun_q;

        if (state_q != ST_RUN && in_valid) begin
            overrun_d = 1'b1;
        end

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (in_valid) begin
                        sig_d   = misr_w;
                        count_d = count_inc;
                        if (count_inc == num_vec_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    // An accepted start clears overrun even if in_valid is
                    // also high this cycle.
                    if (start) begin
                        num_vec_d = num_vec;
                        sig_d     = SEED;
                        count_d   = '0;
                        overrun_d = 1'b0;
                        state_d   = (num_vec == '0) ? ST_DONE : ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sig_q     <= SEED;
            count_q   <= '0;
            num_vec_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            count_q   <= count_d;
            num_vec_q <= num_vec_d;
            overrun_q <= overrun_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign match    = done && (sig_q == golden);
    assign sig      = sig_q;
    assign count    = count_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_expr_result_misr.sv
module tb_expr_result_misr;

    localparam logic [31:0] SEED = 32'h0000_0000;
    localparam logic [31:0] POLY = 32'h0040_0007;
    localparam int          CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_vec = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [89:0]   in_y = '0;
    logic [31:0]   golden = '0;
    logic [31:0]   sig;
    logic [CW-1:0] count;
    logic          done;
    logic          match;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    expr_result_misr #(.SEED(SEED), .POLY(POLY), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vec(num_vec), .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .golden(golden), .sig(sig), .count(count),
        .done(done), .match(match), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the signature is a polynomial shift of the previous
    // value plus the XOR-folded vector, computed with plain arithmetic.
    function automatic logic [31:0] ref_fold(input logic [89:0] y);
        logic [89:0] m;
        m = 90'hFFFF_FFFF;
        return 32'(y & m) ^ 32'((y >> 32) & m) ^ 32'(y >> 64);
    endfunction

    function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [31:0] f);
        logic [32:0] wide;
        wide = {1'b0, s} * 33'd2;
        return 32'(wide % 33'h1_0000_0000) ^ ((s >= 32'h8000_0000) ? POLY : 32'h0) ^ f;
    endfunction

    bit          m_busy = 1'b0;   // a run is collecting vectors
    bit          m_fin  = 1'b0;   // a run has finished
    logic [31:0] m_sig  = SEED;
    int          m_got  = 0;
    int          m_need = 0;
    bit          m_ovr  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_fin = 1'b0; m_sig = SEED; m_got = 0; m_ovr = 1'b0;
        end else begin
            bit was_busy;
            bit took_start;
            was_busy   = m_busy;
            took_start = !abort && !was_busy && start;
            if (!was_busy && in_valid && !took_start) m_ovr = 1'b1;
            if (abort) begin
                m_busy = 1'b0; m_fin = 1'b0;
            end else if (was_busy) begin
                if (in_valid) begin
                    m_sig = ref_misr(m_sig, ref_fold(in_y));
                    m_got = (m_got + 1) % 65536;
                    if (m_got == m_need) begin m_busy = 1'b0; m_fin = 1'b1; end
                end
            end else if (took_start) begin
                m_need = int'(num_vec);
                m_sig  = SEED;
                m_got  = 0;
                m_ovr  = 1'b0;
                m_busy = (m_need != 0);
                m_fin  = (m_need == 0);
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_sig",      sig,                32'(m_sig));
        chk("cyc_count",    32'(count),         32'(m_got));
        chk("cyc_in_ready", 32'(in_ready),      32'(m_busy));
        chk("cyc_done",     32'(done),          32'(m_fin));
        chk("cyc_match",    32'(match),         32'(m_fin && (m_sig == golden)));
        chk("cyc_overrun",  32'(overrun),       32'(m_ovr));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input logic [CW-1:0] n);
        start = 1'b1; num_vec = n;
        step();
        start = 1'b0; num_vec = 16'hBEEF;   // latched value must be used
    endtask

    task automatic send(input logic [89:0] y);
        in_valid = 1'b1; in_y = y;
        step();
        in_valid = 1'b0; in_y = '0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        #1;
        chk("rst_sig", sig, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_match", 32'(match), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // single vector
        do_start(16'd1);
        #1 chk("t1_ready_after_start", 32'(in_ready), 32'h1);
        send(90'h1);
        chk("t1_sig", sig, 32'h0000_0001);
        chk("t1_count", 32'(count), 32'h1);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_ready_low", 32'(in_ready), 32'h0);

        // feedback taps
        do_start(16'd2);
        send({58'h0, 32'h8000_0000});
        chk("t2_sig0", sig, 32'h8000_0000);
        send(90'h0);
        chk("t2_sig1", sig, 32'h0040_0007);
        golden = 32'h0040_0007;
        #1 chk("t2_match1", 32'(match), 32'h1);
        golden = 32'h0;
        #1 chk("t2_match0", 32'(match), 32'h0);
        step();

        // fold
        do_start(16'd1);
        send({26'h1, 32'h1, 32'h1});
        chk("t3_fold_a", sig, 32'h0000_0001);
        do_start(16'd1);
        send({26'h3FF_FFFF, 64'h0});
        chk("t3_fold_b", sig, 32'h03FF_FFFF);

        // gaps, then overrun in DONE, cleared by next start
        do_start(16'd3);
        in_y = {26'h5, 32'h1234_5678, 32'h0F0F_0F0F};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            step();
            #1 chk("t4_count_step", 32'(count), 32'((i + 2) / 2));
        end
        in_valid = 1'b0;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        #1 chk("t4_overrun_set", 32'(overrun), 32'h1);
        do_start(16'd1);
        #1 chk("t4_overrun_clr", 32'(overrun), 32'h0);
        send(90'h3_0000_0000_0000_0000_0001);

        // zero-length run
        do_start(16'd0);
        #1;
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_sig", sig, SEED);
        chk("t5_count", 32'(count), 32'h0);

        // back-to-back stream
        do_start(16'd20);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_y = {26'(i * 7 + 3), 32'(32'hA5A5_0000 + i * 977), 32'(32'h8000_0001 ^ (i << 9))};
            step();
        end
        in_valid = 1'b0;
        #1 chk("t6_count", 32'(count), 32'd20);

        // abort after 2 of 5
        do_start(16'd5);
        send(90'h77);
        send(90'h1_0000_0000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        chk("t7_count_held", 32'(count), 32'h2);
        chk("t7_done", 32'(done), 32'h0);
        chk("t7_ready", 32'(in_ready), 32'h0);

        // abort beats start
        start = 1'b1; abort = 1'b1; num_vec = 16'd1;
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("t8_ready", 32'(in_ready), 32'h0);
        chk("t8_done", 32'(done), 32'h0);

        // async reset mid-run
        do_start(16'd4);
        send(90'h1234);
        in_valid = 1'b1; in_y = 90'h55;
        #1 rst_n = 1'b0;
        #1;
        chk("t9_sig", sig, SEED);
        chk("t9_count", 32'(count), 32'h0);
        chk("t9_ready", 32'(in_ready), 32'h0);
        chk("t9_done", 32'(done), 32'h0);
        chk("t9_overrun", 32'(overrun), 32'h0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        do_start(16'd1);
        send(90'h2);
        chk("t9_after_sig", sig, 32'h0000_0002);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_result_misr.md
# expr_result_misr

Downstream result-compaction stage for the generated expression blocks. It consumes the 90-bit concatenated result bus `y` one vector per handshake and folds each vector into a 32-bit multiple-input signature register (MISR). After a programmed number of vectors it reports the signature and compares it against a golden value. This lets regression benches check millions of expression evaluations with a single 32-bit compare.

## Interface
- `SEED`, 32'h0000_0000, MISR value loaded on start.
- `POLY`, 32'h0040_0007, feedback taps (x^32+x^22+x^2+x+1).
- `CW`, 16, vector-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  begin a run; sampled in IDLE or DONE.
- `abort`  in  1  return to IDLE from any state.
- `num_vec`  in  CW  vectors per run; sampled on start.
- `in_valid`  in  1  `in_y` valid.
- `in_ready`  out  1  block accepts `in_y`.
- `in_y`  in  90  expression result bus.
- `golden`  in  32  expected signature; compared continuously.
- `sig`  out  32  current MISR value.
- `count`  out  CW  vectors accepted this run.
- `done`  out  1  level, high in DONE.
- `match`  out  1  `done && (sig == golden)`.
- `overrun`  out  1  sticky; in_valid seen while not accepting.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - `start` with `num_vec != 0`: go to RUN, `sig <= SEED`, `count <= 0`, `overrun <= 0`.
  - `start` with `num_vec == 0`: go directly to DONE, `sig <= SEED`, `count <= 0`, `overrun <= 0`.
- RUN:
  - `in_ready = 1`.
  - Accept when `in_valid && in_ready`: `sig <= MISR(sig, fold(in_y))` and `count <= count + 1`.
  - If the accepted vector makes `count + 1 == num_vec_latched`, go to DONE on the same edge.
- DONE:
  - `sig` and `count` hold.
  - `start` re-arms exactly as in IDLE.
- fold(y) = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
- MISR(s, f) = {s[30:0], 1'b0} ^ (s[31] ? POLY : 0) ^ f. All widths are 32, unsigned, with no carries.
- `abort`:
  - Highest priority. The next state is IDLE and `sig`/`count` hold their values.
  - Simultaneous `abort` and `start`: abort wins.
- `start` while in RUN is ignored. Only `abort` leaves RUN early.
- `overrun`:
  - Set when `in_valid && !in_ready` in IDLE or DONE.
  - Cleared only by an accepted start or by reset.
- `count` saturates at its width only by construction: the run ends at `num_vec_latched <= 2^CW - 1`.
- `num_vec` is latched on start. Later changes have no effect on the current run.

## Timing
- Reset values: state IDLE, `sig = SEED`, `count = 0`, `done = 0`, `match = 0`, `overrun = 0`, `in_ready = 0`.
- `in_ready`, `done` and `match` are decoded from registered state and registered `sig`. There is no combinational path from `in_valid` or `start` to any output. `golden` to `match` is combinational.
- Throughput: one vector per cycle while `in_valid` stays high in RUN.
- Latency:
  - A vector accepted at edge k appears in `sig` and `count` after edge k.
  - `done` rises after the edge that accepts the final vector.
  - On the edge that takes the FSM to DONE, `in_ready` falls for the next cycle.
- `start` to RUN: 1 edge. `in_ready` is first high in the cycle after the start edge.
- Asynchronous reset mid-run: all registers return to reset values immediately. The run is lost and no `done` is produced.
- Reset deassertion is assumed synchronised externally. The first edge after release behaves as IDLE.

## Test plan
- Reset defaults, then start, `num_vec = 1`, one vector `in_y = 90'h1` -> `sig = 32'h0000_0001`, `count = 1`, `done = 1` one edge after accept.
- `num_vec = 2`, vectors `y = {58'h0, 32'h8000_0000}` then `y = 0` -> `sig` reads 32'h8000_0000, then 32'h0040_0007. Drive `golden = 32'h0040_0007` -> `match = 1`. Drive `golden = 0` -> `match = 0`.
- Fold check: `in_y = {26'h1, 32'h1, 32'h1}`, `num_vec = 1` -> `sig = 32'h0000_0001`. Repeat with `in_y = {26'h3FF_FFFF, 64'h0}` -> `sig = 32'h03FF_FFFF`.
- Back-pressure and gaps in RUN: `num_vec = 3` with `in_valid` toggling 1,0,1,0,1 -> exactly 3 accepts, `count` steps 1,2,3, then `done = 1` and `in_ready = 0`. `in_valid` in DONE -> `overrun = 1`. Next start -> `overrun = 0`.
- Start with `num_vec = 0` -> DONE one edge later with `sig = SEED` and `count = 0`.
- Control priority and reset:
  - Abort after 2 of 5 vectors -> IDLE, `count = 2` held, `done = 0`.
  - `abort` and `start` in the same cycle -> IDLE.
  - Assert `rst_n` low mid-run between edges -> all outputs at reset values immediately.
